// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array drain path.
// Data elements are Q2.13 signed words, carried bit-exact through the collector.
package sa_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 13;
    localparam int unsigned INT_W  = 2;

    // Collector tile sequencing.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_e;

endpackage : sa_pkg

// File: rtl/sa_col_fifo.sv
// Per-column synchronous FIFO, DATA_W x DEPTH, head visible combinationally.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous flush (pointers and count to zero)
//   push        write request; taken when not full, or when full with a pop on the same edge
//   pop         read request; ignored while empty
//   wr_data     element to write
//   rd_data     current head element
//   full/empty  occupancy flags
module sa_col_fifo
    import sa_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : sa_col_fifo

// File: rtl/sa_out_collector.sv
// Drain-side collector for the systolic array bottom edge. Buffers each PE column's
// result stream in its own FIFO to absorb column skew and downstream stalls, then
// pops all columns together to emit one aligned result row per handshake.
// Ports:
//   I_CLK, I_RST_N  clock and asynchronous active-low reset
//   I_START         begin a tile (only honoured in IDLE)
//   I_COL_VLD       per-column element valid
//   I_COL_DATA      per-column element, column c at [16c+15:16c]
//   O_ROW_VLD       result row valid, held until I_ROW_RDY
//   I_ROW_RDY       downstream ready
//   O_ROW_DATA      result row, column c at [16c+15:16c]
//   O_ROW_IDX       row index within the tile
//   O_TILE_DONE     one-cycle pulse after the last row of the tile is taken
//   O_BUSY          high while collecting
//   O_OVF           sticky: an element was dropped on a full column FIFO
module sa_out_collector
    import sa_pkg::*;
#(
    parameter int unsigned COLS  = 4,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                                     I_CLK,
    input  logic                                     I_RST_N,
    input  logic                                     I_START,
    input  logic [COLS-1:0]                          I_COL_VLD,
    input  logic [COLS*DATA_W-1:0]                   I_COL_DATA,
    output logic                                     O_ROW_VLD,
    input  logic                                     I_ROW_RDY,
    output logic [COLS*DATA_W-1:0]                   O_ROW_DATA,
    output logic [$clog2(ROWS)+((ROWS < 2) ? 1 : 0)-1:0] O_ROW_IDX,
    output logic                                     O_TILE_DONE,
    output logic                                     O_BUSY,
    output logic                                     O_OVF
);

    localparam int unsigned IDX_W = $clog2(ROWS) + ((ROWS < 2) ? 1 : 0);
    localparam int unsigned CNT_W = $clog2(ROWS + 1);

    collector_state_e        state;
    logic [CNT_W-1:0]        issue_cnt;   // rows popped into the output register
    logic [CNT_W-1:0]        xfer_cnt;    // rows handed off downstream
    logic [COLS-1:0]         fifo_full;
    logic [COLS-1:0]         fifo_empty;
    logic [COLS-1:0]         push;
    logic [COLS*DATA_W-1:0]  heads;
    logic                    collecting;
    logic                    fifo_clear;
    logic                    xfer;
    logic                    pop;
    logic                    drop;

    assign collecting = (state == COLLECT);
    assign fifo_clear = (state == IDLE);
    assign push       = I_COL_VLD & {COLS{collecting}};
    assign xfer       = O_ROW_VLD & I_ROW_RDY;
    // All columns advance together; the output slot is free or being vacated this edge.
    assign pop        = collecting & (&(~fifo_empty)) & (~O_ROW_VLD | I_ROW_RDY)
                        & (issue_cnt < CNT_W'(ROWS));
    assign drop       = |(push & fifo_full) & ~pop;

    // One FIFO per PE column.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        sa_col_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk    (I_CLK),
            .rst_n  (I_RST_N),
            .clear  (fifo_clear),
            .push   (push[c]),
            .pop    (pop),
            .wr_data(I_COL_DATA[c*DATA_W +: DATA_W]),
            .rd_data(heads[c*DATA_W +: DATA_W]),
            .full   (fifo_full[c]),
            .empty  (fifo_empty[c])
        );
    end

    // Tile FSM, row counters, output row register and overflow flag.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            xfer_cnt    <= '0;
            O_ROW_VLD   <= 1'b0;
            O_ROW_DATA  <= '0;
            O_ROW_IDX   <= '0;
            O_TILE_DONE <= 1'b0;
            O_BUSY      <= 1'b0;
            O_OVF       <= 1'b0;
        end else begin
            O_TILE_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_START) begin
                        state     <= COLLECT;
                        O_BUSY    <= 1'b1;
                        O_OVF     <= 1'b0;
                        issue_cnt <= '0;
                        xfer_cnt  <= '0;
                    end
                end
                COLLECT: begin
                    if (drop) begin
                        O_OVF <= 1'b1;
                    end
                    if (pop) begin
                        O_ROW_DATA <= heads;
                        O_ROW_VLD  <= 1'b1;
                        O_ROW_IDX  <= IDX_W'(issue_cnt);
                        issue_cnt  <= issue_cnt + CNT_W'(1);
                    end else if (xfer) begin
                        O_ROW_VLD <= 1'b0;
                    end
                    if (xfer) begin
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                        if (xfer_cnt == CNT_W'(ROWS - 1)) begin
                            state       <= DONE;
                            O_BUSY      <= 1'b0;
                            O_TILE_DONE <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : sa_out_collector

// File: tb/tb_sa_out_collector.sv
// Bench for sa_out_collector: a directed vector table for the basic skewed tile,
// hand sequences for stall / overflow / full-with-pop / idle / reset corners, and
// a randomized phase checked against a queue-based reference model.
module tb_sa_out_collector;

    localparam int COLS  = 4;
    localparam int ROWS  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  col_vld;
    logic [63:0] col_data;
    logic        row_vld;
    logic        row_rdy;
    logic [63:0] row_data;
    logic [1:0]  row_idx;
    logic        tile_done;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [63:0] got_data [$];
    logic [1:0]  got_idx  [$];

    always #5 clk = ~clk;

    sa_out_collector #(
        .COLS (COLS),
        .ROWS (ROWS),
        .DEPTH(DEPTH)
    ) dut (
        .I_CLK      (clk),
        .I_RST_N    (rst_n),
        .I_START    (start),
        .I_COL_VLD  (col_vld),
        .I_COL_DATA (col_data),
        .O_ROW_VLD  (row_vld),
        .I_ROW_RDY  (row_rdy),
        .O_ROW_DATA (row_data),
        .O_ROW_IDX  (row_idx),
        .O_TILE_DONE(tile_done),
        .O_BUSY     (busy),
        .O_OVF      (ovf)
    );

    typedef struct {
        logic        st;
        logic [3:0]  cv;
        logic [63:0] cd;
        logic        rdy;
        logic        e_vld;
        logic        chk_data;
        logic [63:0] e_data;
        logic [1:0]  e_idx;
        logic        e_done;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row r of the reference tile: column c carries 16*r + c.
    function automatic logic [63:0] row_val(input int r);
        logic [63:0] v;
        for (int c = 0; c < COLS; c++) v[16*c +: 16] = 16'(16*r + c);
        return v;
    endfunction

    // Skewed feed: column c delivers row (t - c) in feed cycle t.
    function automatic void feed(input int t, output logic [3:0] v, output logic [63:0] d);
        v = '0;
        d = '0;
        for (int c = 0; c < COLS; c++) begin
            int r;
            r = t - c;
            if (r >= 0 && r < ROWS) begin
                v[c] = 1'b1;
                d[16*c +: 16] = 16'(16*r + c);
            end else begin
                d[16*c +: 16] = 16'hA5A0 + 16'(c);
            end
        end
    endfunction

    // One clock: drive inputs, log a handshake seen before the edge, sample after it.
    task automatic cyc(input logic st, input logic [3:0] v, input logic [63:0] d, input logic rdy);
        start    = st;
        col_vld  = v;
        col_data = d;
        row_rdy  = rdy;
        if (row_vld && rdy) begin
            got_data.push_back(row_data);
            got_idx.push_back(row_idx);
        end
        @(posedge clk);
        #1;
        if (tile_done) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 64'h0, 1'b1);
    endtask

    task automatic check_rows(input string name, input int n);
        check({name, "_nrows"}, 64'(got_data.size()), 64'(n));
        for (int i = 0; i < got_data.size() && i < n; i++) begin
            check($sformatf("%s_row%0d_data", name, i), got_data[i], row_val(i));
            check($sformatf("%s_row%0d_idx", name, i), 64'(got_idx[i]), 64'(i));
        end
        got_data.delete();
        got_idx.delete();
        done_cnt = 0;
    endtask

    task automatic fill_table();
        for (int i = 0; i < 11; i++) begin
            tbl[i].st = (i == 0);
            feed(i - 1, tbl[i].cv, tbl[i].cd);
            tbl[i].rdy      = 1'b1;
            tbl[i].e_vld    = 1'b0;
            tbl[i].chk_data = 1'b0;
            tbl[i].e_data   = 64'h0;
            tbl[i].e_idx    = 2'd0;
            tbl[i].e_done   = 1'b0;
            tbl[i].e_busy   = (i <= 8);
            tbl[i].e_ovf    = 1'b0;
        end
        tbl[5].e_vld = 1'b1; tbl[5].chk_data = 1'b1; tbl[5].e_data = 64'h0003_0002_0001_0000; tbl[5].e_idx = 2'd0;
        tbl[6].e_vld = 1'b1; tbl[6].chk_data = 1'b1; tbl[6].e_data = 64'h0013_0012_0011_0010; tbl[6].e_idx = 2'd1;
        tbl[7].e_vld = 1'b1; tbl[7].chk_data = 1'b1; tbl[7].e_data = 64'h0023_0022_0021_0020; tbl[7].e_idx = 2'd2;
        tbl[8].e_vld = 1'b1; tbl[8].chk_data = 1'b1; tbl[8].e_data = 64'h0033_0032_0031_0030; tbl[8].e_idx = 2'd3;
        tbl[9].e_done = 1'b1; tbl[9].chk_data = 1'b1; tbl[9].e_data = 64'h0033_0032_0031_0030;
    endtask

    task automatic apply_table(input string name);
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].st, tbl[i].cv, tbl[i].cd, tbl[i].rdy);
            check($sformatf("%s%0d_vld", name, i), 64'(row_vld), 64'(tbl[i].e_vld));
            check($sformatf("%s%0d_busy", name, i), 64'(busy), 64'(tbl[i].e_busy));
            check($sformatf("%s%0d_done", name, i), 64'(tile_done), 64'(tbl[i].e_done));
            check($sformatf("%s%0d_ovf", name, i), 64'(ovf), 64'(tbl[i].e_ovf));
            if (tbl[i].chk_data) check($sformatf("%s%0d_data", name, i), row_data, tbl[i].e_data);
            if (tbl[i].e_vld) check($sformatf("%s%0d_idx", name, i), 64'(row_idx), 64'(tbl[i].e_idx));
        end
        got_data.delete();
        got_idx.delete();
        done_cnt = 0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_vld"},  64'(row_vld),   64'h0);
        check({name, "_data"}, row_data,       64'h0);
        check({name, "_idx"},  64'(row_idx),   64'h0);
        check({name, "_done"}, 64'(tile_done), 64'h0);
        check({name, "_busy"}, 64'(busy),      64'h0);
        check({name, "_ovf"},  64'(ovf),       64'h0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) cyc(1'b0, 4'h0, 64'h0, 1'b1);
    endtask

    // Downstream stalls for 5 cycles once the first row appears.
    task automatic scen_stall();
        int  stall = 0;
        bit  seen  = 0;
        logic [3:0]  v;
        logic [63:0] d;
        logic        rdy;
        cyc(1'b1, 4'h0, 64'h0, 1'b1);
        for (int t = 0; t < 40 && done_cnt == 0; t++) begin
            feed(t, v, d);
            if (row_vld) seen = 1;
            rdy = 1'b1;
            if (seen && stall < 5) begin
                check($sformatf("stall_vld%0d", stall), 64'(row_vld), 64'h1);
                check($sformatf("stall_data%0d", stall), row_data, row_val(0));
                stall++;
                rdy = 1'b0;
            end
            cyc(1'b0, v, d, rdy);
        end
        check("stall_done", 64'(done_cnt), 64'h1);
        check("stall_ovf", 64'(ovf), 64'h0);
        check_rows("stall", 4);
        idle(1);
    endtask

    // Column 0 overfilled while nothing can drain; fifth element must be lost.
    task automatic scen_ovf();
        cyc(1'b1, 4'h0, 64'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b0001, {48'h0, (k < 4) ? 16'(16*k) : 16'h0BAD}, 1'b0);
            if (k == 3) check("ovf_after4", 64'(ovf), 64'h0);
            if (k == 4) check("ovf_after5", 64'(ovf), 64'h1);
        end
        for (int r = 0; r < 4; r++) cyc(1'b0, 4'b1110, (row_val(r) & ~64'hFFFF) | 64'h0BAD, 1'b0);
        cyc(1'b0, 4'h0, 64'h0, 1'b0);
        check("ovf_held_vld", 64'(row_vld), 64'h1);
        check("ovf_held_data", row_data, row_val(0));
        drain(20);
        check("ovf_done", 64'(done_cnt), 64'h1);
        check("ovf_sticky", 64'(ovf), 64'h1);
        check_rows("ovf", 4);
        idle(1);
    endtask

    // All FIFOs full with a row pending; handshake and push on the same edge.
    task automatic scen_full_pushpop();
        cyc(1'b1, 4'h0, 64'h0, 1'b0);
        check("start_clears_ovf", 64'(ovf), 64'h0);
        for (int r = 0; r < 5; r++) cyc(1'b0, 4'hF, row_val(r), 1'b0);
        check("full_vld", 64'(row_vld), 64'h1);
        check("full_data", row_data, row_val(0));
        cyc(1'b0, 4'hF, row_val(5), 1'b1);
        check("full_pushpop_ovf", 64'(ovf), 64'h0);
        check("full_pushpop_data", row_data, row_val(1));
        check("full_pushpop_idx", 64'(row_idx), 64'h1);
        drain(20);
        check("full_done", 64'(done_cnt), 64'h1);
        check("full_ovf_end", 64'(ovf), 64'h0);
        check_rows("full", 4);
        idle(1);
    endtask

    task automatic scen_idle_pulses();
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 4'($urandom_range(1, 15)), {$urandom, $urandom}, 1'b1);
            check($sformatf("idle%0d_vld", k), 64'(row_vld), 64'h0);
            check($sformatf("idle%0d_ovf", k), 64'(ovf), 64'h0);
            check($sformatf("idle%0d_busy", k), 64'(busy), 64'h0);
        end
        apply_table("tblb");
    endtask

    task automatic scen_reset_mid();
        logic [3:0]  v;
        logic [63:0] d;
        cyc(1'b1, 4'h0, 64'h0, 1'b1);
        for (int t = 0; t < 20 && got_data.size() < 2; t++) begin
            feed(t, v, d);
            cyc(1'b0, v, d, 1'b1);
        end
        check_rows("pre_rst", 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        start = 1'b0; col_vld = '0; col_data = '0; row_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_table("tblc");
    endtask

    // Reference model: per-column queues and a pending-row slot.
    logic [15:0] mq [COLS][$];
    bit          m_vld, m_busy, m_done, m_ovf;
    int          m_idx, m_issued, m_xfer;
    logic [63:0] m_data;

    task automatic model_reset();
        for (int c = 0; c < COLS; c++) mq[c].delete();
        m_vld = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        m_idx = 0; m_issued = 0; m_xfer = 0; m_data = '0;
    endtask

    task automatic model_edge(input logic st, input logic [3:0] v, input logic [63:0] d, input logic rdy);
        bit idle_now;
        bit hs;
        bit all_ne;
        bit pop;
        idle_now = !m_busy && !m_done;
        hs       = m_vld && rdy;
        all_ne   = 1;
        for (int c = 0; c < COLS; c++) if (mq[c].size() == 0) all_ne = 0;
        pop    = m_busy && all_ne && (!m_vld || rdy) && (m_issued < ROWS);
        m_done = 0;
        if (m_busy) begin
            if (pop) begin
                for (int c = 0; c < COLS; c++) m_data[16*c +: 16] = mq[c].pop_front();
                m_vld = 1;
                m_idx = m_issued;
                m_issued++;
            end else if (hs) begin
                m_vld = 0;
            end
            for (int c = 0; c < COLS; c++) begin
                if (v[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(d[16*c +: 16]);
                    else m_ovf = 1;
                end
            end
            if (hs) begin
                m_xfer++;
                if (m_xfer == ROWS) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            for (int c = 0; c < COLS; c++) mq[c].delete();
            if (idle_now && st) begin
                m_busy = 1; m_ovf = 0; m_issued = 0; m_xfer = 0;
            end
        end
    endtask

    task automatic scen_random();
        int          n = 0;
        int          dens;
        int          rdy_pct;
        logic        st;
        logic [3:0]  v;
        logic [63:0] d;
        logic        rdy;
        rst_n = 1'b0;
        start = 1'b0; col_vld = '0; col_data = '0; row_rdy = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int tile = 0; tile < 12; tile++) begin
            dens    = $urandom_range(30, 90);
            rdy_pct = $urandom_range(20, 100);
            for (int i = 0; i < 100; i++) begin
                st = (i == 0) ? 1'b1 : ($urandom_range(0, 19) == 0);
                for (int c = 0; c < COLS; c++) v[c] = ($urandom_range(0, 99) < dens);
                d   = {$urandom, $urandom};
                rdy = ($urandom_range(0, 99) < rdy_pct);
                model_edge(st, v, d, rdy);
                cyc(st, v, d, rdy);
                check($sformatf("rnd%0d_vld", n),  64'(row_vld),   64'(m_vld));
                check($sformatf("rnd%0d_data", n), row_data,       m_data);
                check($sformatf("rnd%0d_busy", n), 64'(busy),      64'(m_busy));
                check($sformatf("rnd%0d_done", n), 64'(tile_done), 64'(m_done));
                check($sformatf("rnd%0d_ovf", n),  64'(ovf),       64'(m_ovf));
                if (m_vld) check($sformatf("rnd%0d_idx", n), 64'(row_idx), 64'(m_idx));
                n++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        col_vld  = '0;
        col_data = '0;
        row_rdy  = 1'b0;
        fill_table();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        apply_table("tbla");
        scen_stall();
        scen_ovf();
        scen_full_pushpop();
        scen_idle_pulses();
        scen_reset_mid();
        scen_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

endmodule : tb_sa_out_collector
